// File: rtl/package_settings.sv
// Shared settings for the filter chain: sample width plus the peak-finder
// event record and FSM state types.
package package_settings;

    localparam int SIZE_FILTER_DATA = 16;

    // Record field widths are fixed here because the event struct is shared.
    localparam int TS_WIDTH   = 16;
    localparam int WIDTH_BITS = 8;

    typedef enum logic [1:0] {
        PF_IDLE    = 2'd0,
        PF_PULSE   = 2'd1,
        PF_HOLDOFF = 2'd2
    } peak_state_t;

    typedef struct packed {
        logic signed [SIZE_FILTER_DATA-1:0] amplitude;
        logic [TS_WIDTH-1:0]                time_tag;
        logic [WIDTH_BITS-1:0]              width;
        logic                               pileup;
    } peak_event_t;

endpackage

// File: rtl/peak_event_fifo.sv
// Synchronous show-ahead FIFO of peak event records. A push is accepted when
// full only if a pop happens on the same edge.
module peak_event_fifo
    import package_settings::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  peak_event_t push_data,
    output peak_event_t pop_data,
    output logic        full,
    output logic        empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    peak_event_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

    assign pop_data = mem[rd_ptr_reg];

endmodule

// File: rtl/filter_peak_finder.sv
// Pulse detector on a filtered sample stream: measures amplitude, peak time
// and width of each pulse above threshold and queues the result as an event.
module filter_peak_finder
    import package_settings::*;
#(
    parameter int HOLDOFF    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic signed [SIZE_FILTER_DATA-1:0] input_data,
    input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
    output logic                               event_valid,
    input  logic                               event_ready,
    output logic signed [SIZE_FILTER_DATA-1:0] event_amplitude,
    output logic [TS_WIDTH-1:0]                event_time,
    output logic [WIDTH_BITS-1:0]              event_width,
    output logic                               event_pileup,
    output logic [7:0]                         lost_count,
    output logic                               busy
);
    localparam int HCW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HCW-1:0]        HOLD_LOAD = HCW'(HOLDOFF - 1);
    localparam logic [WIDTH_BITS-1:0] WIDTH_MAX = '1;

    logic signed [SIZE_FILTER_DATA-1:0] s_q_reg;
    logic [TS_WIDTH-1:0]                tag_reg;
    logic [TS_WIDTH-1:0]                ts_reg;
    peak_state_t                        state_reg;
    logic signed [SIZE_FILTER_DATA-1:0] max_reg;
    logic [TS_WIDTH-1:0]                t_max_reg;
    logic [WIDTH_BITS-1:0]              width_reg;
    logic                               pileup_reg;
    logic                               pending_reg;
    logic [HCW-1:0]                     hold_cnt_reg;
    logic                               push_reg;
    peak_event_t                        push_rec_reg;
    logic [7:0]                         lost_reg;

    logic        above;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    peak_event_t fifo_out;

    assign above = s_q_reg > threshold;

    // Every decision uses the registered sample, tagged with its capture time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_q_reg <= '0;
            tag_reg <= '0;
            ts_reg  <= '0;
        end else begin
            s_q_reg <= input_data;
            tag_reg <= ts_reg;
            ts_reg  <= ts_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= PF_IDLE;
            max_reg      <= '0;
            t_max_reg    <= '0;
            width_reg    <= '0;
            pileup_reg   <= 1'b0;
            pending_reg  <= 1'b0;
            hold_cnt_reg <= '0;
            push_reg     <= 1'b0;
            push_rec_reg <= '0;
        end else begin
            push_reg <= 1'b0;
            case (state_reg)
                PF_IDLE: begin
                    if (above) begin
                        state_reg   <= PF_PULSE;
                        max_reg     <= s_q_reg;
                        t_max_reg   <= tag_reg;
                        width_reg   <= {{(WIDTH_BITS-1){1'b0}}, 1'b1};
                        pileup_reg  <= pending_reg;
                        pending_reg <= 1'b0;
                    end
                end
                PF_PULSE: begin
                    if (above) begin
                        if (width_reg == WIDTH_MAX) pileup_reg <= 1'b1;
                        else                        width_reg  <= width_reg + 1'b1;
                        // Strict compare keeps the earliest sample of a plateau.
                        if (s_q_reg > max_reg) begin
                            max_reg   <= s_q_reg;
                            t_max_reg <= tag_reg;
                        end
                    end else begin
                        push_reg     <= 1'b1;
                        push_rec_reg <= '{max_reg, t_max_reg, width_reg, pileup_reg};
                        state_reg    <= PF_HOLDOFF;
                        hold_cnt_reg <= HOLD_LOAD;
                    end
                end
                PF_HOLDOFF: begin
                    if (above) pending_reg <= 1'b1;
                    if (hold_cnt_reg == '0) state_reg    <= PF_IDLE;
                    else                    hold_cnt_reg <= hold_cnt_reg - 1'b1;
                end
                default: state_reg <= PF_IDLE;
            endcase
        end
    end

    assign pop = event_ready && !fifo_empty;

    peak_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_reg),
        .pop       (pop),
        .push_data (push_rec_reg),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lost_reg <= '0;
        end else if (push_reg && fifo_full && !pop && lost_reg != 8'hFF) begin
            lost_reg <= lost_reg + 1'b1;
        end
    end

    // Fields read as zero whenever no record is held.
    assign event_valid     = !fifo_empty;
    assign event_amplitude = fifo_empty ? '0 : fifo_out.amplitude;
    assign event_time      = fifo_empty ? '0 : fifo_out.time_tag;
    assign event_width     = fifo_empty ? '0 : fifo_out.width;
    assign event_pileup    = fifo_empty ? 1'b0 : fifo_out.pileup;
    assign lost_count      = lost_reg;
    assign busy            = (state_reg != PF_IDLE);

endmodule

// File: tb/tb_filter_peak_finder.sv
// Bench for filter_peak_finder: directed vector table, multi-cycle corner
// sequences and random streams checked against a pulse-scanning model.
module tb_filter_peak_finder;
    import package_settings::*;

    localparam int HOLDOFF    = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int MAXN       = 1024;

    logic                               clk = 1'b0;
    logic                               reset;
    logic signed [SIZE_FILTER_DATA-1:0] input_data;
    logic signed [SIZE_FILTER_DATA-1:0] threshold;
    logic                               event_valid;
    logic                               event_ready;
    logic signed [SIZE_FILTER_DATA-1:0] event_amplitude;
    logic [TS_WIDTH-1:0]                event_time;
    logic [WIDTH_BITS-1:0]              event_width;
    logic                               event_pileup;
    logic [7:0]                         lost_count;
    logic                               busy;

    filter_peak_finder #(
        .HOLDOFF    (HOLDOFF),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .input_data      (input_data),
        .threshold       (threshold),
        .event_valid     (event_valid),
        .event_ready     (event_ready),
        .event_amplitude (event_amplitude),
        .event_time      (event_time),
        .event_width     (event_width),
        .event_pileup    (event_pileup),
        .lost_count      (lost_count),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int amp;
        int t;
        int w;
        int p;
        int edge_no;
    } ev_t;

    typedef struct {
        int thr;
        int s[8];
        int cnt;
        int amp;
        int t;
        int w;
        int p;
        int vedge;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   samp [MAXN];
    int   mlost;
    ev_t  sched [$];
    ev_t  mq [$];
    ev_t  popped [$];
    vec_t vecs [6];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b0;
        input_data  = '0;
        event_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Scan the sample list pulse by pulse; sample k is captured on edge k with tag k,
    // and a pulse whose first below sample is j becomes visible after edge j+2.
    task automatic build_model(input int n, input int thr);
        int  i;
        int  j;
        int  mx;
        int  ti;
        int  len;
        bit  pend;
        ev_t ev;
        sched.delete();
        i    = 0;
        pend = 1'b0;
        while (i < n) begin
            if (samp[i] > thr) begin
                j  = i;
                mx = samp[i];
                ti = i;
                while (j < n && samp[j] > thr) begin
                    if (samp[j] > mx) begin
                        mx = samp[j];
                        ti = j;
                    end
                    j++;
                end
                if (j >= n) break;
                len        = j - i;
                ev.amp     = mx;
                ev.t       = ti % 65536;
                ev.w       = (len > 255) ? 255 : len;
                ev.p       = (pend || len > 255) ? 1 : 0;
                ev.edge_no = j + 2;
                sched.push_back(ev);
                pend = 1'b0;
                for (int k = j + 1; k <= j + HOLDOFF && k < n; k++)
                    if (samp[k] > thr) pend = 1'b1;
                i = j + HOLDOFF + 1;
            end else begin
                i++;
            end
        end
    endtask

    // mode 0: always ready, 1: mostly ready, 2: rarely ready, 3: ready from edge `split`
    task automatic run_stream(input int n, input int thr, input int mode, input int split,
                              input string name);
        do_reset();
        threshold = 16'(thr);
        build_model(n, thr);
        mq.delete();
        popped.delete();
        mlost = 0;
        for (int e = 0; e < n; e++) begin
            bit  r;
            ev_t ev;
            case (mode)
                0:       r = 1'b1;
                1:       r = ($urandom_range(0, 3) != 0);
                2:       r = ($urandom_range(0, 3) == 0);
                default: r = (e >= split);
            endcase
            input_data  = 16'(samp[e]);
            event_ready = r;
            if (event_valid && r) begin
                ev.amp     = int'(event_amplitude);
                ev.t       = int'(event_time);
                ev.w       = int'(event_width);
                ev.p       = int'(event_pileup);
                ev.edge_no = e;
                popped.push_back(ev);
            end
            if (r && mq.size() > 0) void'(mq.pop_front());
            while (sched.size() > 0 && sched[0].edge_no == e) begin
                ev = sched.pop_front();
                if (mq.size() < FIFO_DEPTH) mq.push_back(ev);
                else if (mlost < 255)       mlost++;
            end
            @(negedge clk);
            chk({name, ".valid"}, event_valid, (mq.size() > 0) ? 1 : 0);
            if (mq.size() > 0) begin
                chk({name, ".amp"},    event_amplitude, mq[0].amp);
                chk({name, ".time"},   event_time,      mq[0].t);
                chk({name, ".width"},  event_width,     mq[0].w);
                chk({name, ".pileup"}, event_pileup,    mq[0].p);
            end
            chk({name, ".lost"}, lost_count, mlost);
        end
    endtask

    task automatic run_vectors();
        for (int v = 0; v < 6; v++) begin
            int nseen;
            int fe;
            int a;
            int t;
            int w;
            int p;
            do_reset();
            threshold = 16'(vecs[v].thr);
            nseen = 0;
            fe = -1; a = 0; t = 0; w = 0; p = 0;
            for (int e = 0; e < 20; e++) begin
                input_data  = (e < 8) ? 16'(vecs[v].s[e]) : 16'd0;
                event_ready = 1'b1;
                @(negedge clk);
                if (event_valid) begin
                    if (nseen == 0) begin
                        fe = e;
                        a  = int'(event_amplitude);
                        t  = int'(event_time);
                        w  = int'(event_width);
                        p  = int'(event_pileup);
                    end
                    nseen++;
                end
            end
            chk($sformatf("vec%0d.count", v), nseen, vecs[v].cnt);
            if (vecs[v].cnt > 0) begin
                chk($sformatf("vec%0d.amp", v),    a,  vecs[v].amp);
                chk($sformatf("vec%0d.time", v),   t,  vecs[v].t);
                chk($sformatf("vec%0d.width", v),  w,  vecs[v].w);
                chk($sformatf("vec%0d.pileup", v), p,  vecs[v].p);
                chk($sformatf("vec%0d.latency", v), fe, vecs[v].vedge);
            end
        end
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 110; i++) samp[i] = 0;
        for (int k = 0; k < 6; k++) begin
            samp[2 + 12*k] = 150;
            samp[3 + 12*k] = 201 + k;
        end
        run_stream(110, 100, 3, 90, "full");
        chk("full.lost_final", lost_count, 2);
        chk("full.pops", popped.size(), 4);
        for (int k = 0; k < 4 && k < popped.size(); k++)
            chk($sformatf("full.order%0d", k), popped[k].amp, 201 + k);
        chk("full.valid_end", event_valid, 0);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 340; i++) samp[i] = (i >= 1 && i <= 300) ? 500 : 0;
        run_stream(340, 100, 0, 0, "sat");
        chk("sat.events", popped.size(), 1);
        if (popped.size() > 0) begin
            chk("sat.width", popped[0].w, 255);
            chk("sat.pileup", popped[0].p, 1);
            chk("sat.amp", popped[0].amp, 500);
            chk("sat.time", popped[0].t, 1);
        end
    endtask

    task automatic test_holdoff();
        for (int i = 0; i < 40; i++) samp[i] = 0;
        samp[2] = 150; samp[3] = 180; samp[4] = 160;
        samp[8] = 300; samp[9] = 300;
        samp[16] = 100;
        samp[20] = 140; samp[21] = 170;
        run_stream(40, 100, 0, 0, "hold");
        chk("hold.events", popped.size(), 2);
        if (popped.size() == 2) begin
            chk("hold.first_amp", popped[0].amp, 180);
            chk("hold.first_pileup", popped[0].p, 0);
            chk("hold.second_amp", popped[1].amp, 170);
            chk("hold.second_time", popped[1].t, 21);
            chk("hold.second_width", popped[1].w, 2);
            chk("hold.second_pileup", popped[1].p, 1);
        end
    endtask

    task automatic test_reset_mid();
        int t6 [16] = '{0, 300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 250, 250, 250};
        int cnt;
        do_reset();
        threshold = 16'sd100;
        for (int e = 0; e < 16; e++) begin
            input_data  = 16'(t6[e]);
            event_ready = 1'b0;
            @(negedge clk);
        end
        chk("rst.busy_before", busy, 1);
        chk("rst.valid_before", event_valid, 1);
        reset = 1'b0;
        #1;
        chk("rst.valid", event_valid, 0);
        chk("rst.amp", event_amplitude, 0);
        chk("rst.time", event_time, 0);
        chk("rst.width", event_width, 0);
        chk("rst.pileup", event_pileup, 0);
        chk("rst.lost", lost_count, 0);
        chk("rst.busy", busy, 0);
        @(negedge clk);
        reset       = 1'b1;
        input_data  = '0;
        event_ready = 1'b1;
        cnt = 0;
        for (int e = 0; e < 20; e++) begin
            @(negedge clk);
            if (event_valid || busy) cnt++;
        end
        chk("rst.quiet_after_release", cnt, 0);
    endtask

    task automatic gen_random(input int thr, output int n);
        n = 0;
        while (n < 560) begin
            int gap = $urandom_range(0, 14);
            int len = $urandom_range(1, 12);
            for (int k = 0; k < gap; k++) begin
                samp[n] = int'($urandom_range(0, thr + 300)) - 300;
                n++;
            end
            for (int k = 0; k < len; k++) begin
                samp[n] = thr + 1 + int'($urandom_range(0, 400));
                n++;
            end
        end
        for (int k = 0; k < 30; k++) begin
            samp[n] = 0;
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int thr;
        vecs[0] = '{100, '{0, 50, 150, 300, 200, 80, 0, 0},     1, 300, 3, 3, 0, 7};
        vecs[1] = '{100, '{0, 200, 250, 250, 90, 0, 0, 0},      1, 250, 2, 3, 0, 6};
        vecs[2] = '{100, '{0, 100, 100, 100, 0, 0, 0, 0},       0, 0,   0, 0, 0, 0};
        vecs[3] = '{10,  '{0, -300, 40, 20, -1, 0, 0, 0},       1, 40,  2, 2, 0, 6};
        vecs[4] = '{100, '{0, 0, 0, 500, 0, 0, 0, 0},           1, 500, 3, 1, 0, 6};
        vecs[5] = '{100, '{0, 120, 130, 140, 100, 0, 0, 0},     1, 140, 3, 3, 0, 6};

        reset       = 1'b0;
        input_data  = '0;
        threshold   = 16'sd100;
        event_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("init.valid", event_valid, 0);
        chk("init.amp", event_amplitude, 0);
        chk("init.lost", lost_count, 0);
        chk("init.busy", busy, 0);
        reset = 1'b1;

        run_vectors();
        test_fifo_full();
        test_saturate();
        test_holdoff();
        test_reset_mid();

        for (int r = 0; r < 3; r++) begin
            thr = $urandom_range(50, 200);
            gen_random(thr, n);
            run_stream(n, thr, r + 1 == 3 ? 0 : r + 1, 0, $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
